// File: rtl/rs_syndrome.sv
// Reed-Solomon syndrome generator over GF(256) (poly 0x11D), computing S0..S3 by Horner's rule.
// Optional `RS_SYND_ZERO_FLAG_EN adds a registered o_zero flag (all syndromes zero).
module rs_syndrome #(
  parameter int NBYTES = 32
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_s0,
  output logic [7:0] o_s1,
  output logic [7:0] o_s2,
  output logic [7:0] o_s3
`ifdef RS_SYND_ZERO_FLAG_EN
  ,
  output logic       o_zero
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(NBYTES - 1);

  state_t     state, state_nxt;
  logic [7:0] cnt;
  logic       accept;
  logic       last;
  logic [7:0] s0_nxt, s1_nxt, s2_nxt, s3_nxt;

  // Multiply by alpha (x) modulo x^8+x^4+x^3+x^2+1.
  function automatic logic [7:0] mul_a(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
  endfunction

  assign accept = (state == ACCUM) && i_valid && !i_start;
  assign last   = accept && (cnt == LAST_IDX);

  always_comb begin
    s0_nxt = o_s0 ^ i_data;
    s1_nxt = mul_a(o_s1) ^ i_data;
    s2_nxt = mul_a(mul_a(o_s2)) ^ i_data;
    s3_nxt = mul_a(mul_a(mul_a(o_s3))) ^ i_data;
  end

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    if (i_start) begin
      state_nxt = ACCUM;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        ACCUM:   if (last) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt  <= 8'd0;
      o_s0 <= 8'h00;
      o_s1 <= 8'h00;
      o_s2 <= 8'h00;
      o_s3 <= 8'h00;
    end else if (i_start) begin
      cnt  <= 8'd0;
      o_s0 <= 8'h00;
      o_s1 <= 8'h00;
      o_s2 <= 8'h00;
      o_s3 <= 8'h00;
    end else if (accept) begin
      cnt  <= cnt + 8'd1;
      o_s0 <= s0_nxt;
      o_s1 <= s1_nxt;
      o_s2 <= s2_nxt;
      o_s3 <= s3_nxt;
    end
  end

  assign o_busy = (state == ACCUM);
  assign o_done = (state == DONE);

`ifdef RS_SYND_ZERO_FLAG_EN
  // Captured with the final byte so it is valid in DONE and held through the following IDLE.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)        o_zero <= 1'b0;
    else if (i_start) o_zero <= 1'b0;
    else if (last)    o_zero <= ((s0_nxt | s1_nxt | s2_nxt | s3_nxt) == 8'h00);
  end
`endif

endmodule
